// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and helpers for the bit-serial arithmetic cells.
//   state_t   - controller state, 2-bit encoding (IDLE, RUN, DONE)
//   cnt_width - bit width of the bit-position counter for a given operand width
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // max(1, $clog2(w)); the counter only has to reach w-1.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_add.sv
// full_add: single-bit full adder cell, purely combinational.
//   a, b, cin - addend bits and carry in
//   s         - sum bit
//   cout      - carry out (majority of the three inputs)
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock
// through a single full_add cell with a registered carry.
//   clk, rst_n - clock, async active-low reset
//   start      - request strobe, accepted in IDLE or DONE
//   a, b, cin  - operands and carry in, sampled on the accept edge
//   busy       - high while bits are being processed
//   done       - one-cycle pulse, sum/cout updated in the same cycle
//   sum, cout  - (a+b+cin) mod 2^WIDTH and carry out, held until next done
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Holds the WIDTH-1 bits already produced; the bit of the current cycle
  // completes the word, so the final result is {bit_s, r_sh}.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, bit_c;
  logic             load, last;

  full_add u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign r_nxt = {bit_s, r_sh};
  assign last  = (cnt == LAST);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        // back-to-back accept from DONE behaves exactly like IDLE
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      r_sh  <= r_nxt[WIDTH-1:1];
      carry <= bit_c;
      if (last) begin
        sum  <= r_nxt;
        cout <= bit_c;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] hold_sum;
  logic         hold_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Presents start with operands, then walks windows
  // 1..W+1 after the accept edge. Returns at the negedge of the done window
  // with start low, so a caller may issue the next op back-to-back.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc, input logic [W-1:0] es, input logic ec,
                       input bit disturb);
    start = 1'b1; a = oa; b = ob; cin = oc;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~oa; b = ~ob; cin = ~oc;   // operands are don't-care after accept
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".nodone"}, 64'(done), 64'd0);
        chk({tag, ".hold_sum"}, 64'(sum), 64'(hold_sum));
        chk({tag, ".hold_cout"}, 64'(cout), 64'(hold_cout));
        if (disturb && k == 3) begin start = 1'b1; a = '0; b = '0; end
        if (disturb && k == 4) start = 1'b0;
      end else begin
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
        chk({tag, ".sum"}, 64'(sum), 64'(es));
        chk({tag, ".cout"}, 64'(cout), 64'(ec));
        hold_sum  = es;
        hold_cout = ec;
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   ref_v;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    hold_sum = '0; hold_cout = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.sum",  64'(sum),  64'd0);
    chk("rst.cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    // no start: nothing moves
    repeat (3) begin
      @(negedge clk);
      chk("quiet.busy", 64'(busy), 64'd0);
      chk("quiet.done", 64'(done), 64'd0);
    end

    do_op("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0);
    @(negedge clk);
    do_op("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    do_op("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    do_op("disturb", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    // back-to-back: start asserted in the DONE cycle
    do_op("b2b", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.idle", 64'(busy | done), 64'd0);

    // reset mid-run
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.sum",  64'(sum),  64'd0);
    chk("abort.cout", 64'(cout), 64'd0);
    hold_sum = '0; hold_cout = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("abort.nodone", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // random against a+b+cin, mixing idle gaps and back-to-back issue
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      do_op("rand", ra, rb, rc, ref_v[W-1:0], ref_v[W], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
